// File: rtl/prog_timer_pkg.sv
// Shared types and defaults for the programmable interval timer.
// Optional mid-period strobe: define PROG_TIMER_MID_EN.
package prog_timer_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_PRESC_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prog_timer_tick.sv
// Prescaler: emits one tick every presc+1 enabled cycles.
// clr has priority over en so a new period always starts from zero.
module prog_timer_tick
  import prog_timer_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt;

  assign tick = en && (pcnt == presc);

  // prescale counter: wrap on tick, else count while enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      if (tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable interval timer: one-shot / periodic, prescaled ticks.
// Optional mid-period strobe port enabled by PROG_TIMER_MID_EN.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [WIDTH-1:0]   value,
  input  logic [PRESC_W-1:0] presc,
  output logic               busy,
  output logic               done,
  output logic               err,
`ifdef PROG_TIMER_MID_EN
  output logic               mid,
`endif
  output logic [WIDTH-1:0]   cnt
);

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  state_t             state;
  state_t             state_d;
  logic               mode_q;
  logic [WIDTH-1:0]   n_q;
  logic [PRESC_W-1:0] p_q;

  logic [WIDTH-1:0]   cnt_d;
  logic               done_d;
  logic               err_d;
  logic               load;
  logic               clr;
  logic               tick;
  logic [WIDTH-1:0]   n_m1;
  logic               term;

  assign n_m1 = n_q - ONE;
  assign term = (cnt == n_m1);
  assign busy = (state == ST_RUN);

`ifdef PROG_TIMER_MID_EN
  logic [WIDTH-1:0] half_m1;
  logic             mid_hit;
  logic             mid_d;

  assign half_m1 = (n_q >> 1) - ONE;
  // N == 1 has no interior point; strobe alongside done
  assign mid_hit = (n_q == ONE) ? term
                                : (cnt == half_m1);
`endif

  prog_timer_tick #(
    .PRESC_W (PRESC_W)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (busy),
    .presc (p_q),
    .tick  (tick)
  );

  // next state: stop > start > tick counting
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    clr     = 1'b0;
`ifdef PROG_TIMER_MID_EN
    mid_d   = 1'b0;
`endif
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      clr     = 1'b1;
    end else if (start) begin
      cnt_d = '0;
      clr   = 1'b1;
      if (value == '0) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        load    = 1'b1;
        state_d = ST_RUN;
      end
    end else if (busy && tick) begin
`ifdef PROG_TIMER_MID_EN
      mid_d = mid_hit;
`endif
      if (term) begin
        cnt_d  = '0;
        done_d = 1'b1;
        if (mode_q == MODE_ONESHOT) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end
      end else begin
        cnt_d = cnt + ONE;
      end
    end
  end

  // state, counter, pulses and latched config
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      mode_q <= MODE_ONESHOT;
      n_q    <= '0;
      p_q    <= '0;
`ifdef PROG_TIMER_MID_EN
      mid    <= 1'b0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      done  <= done_d;
      err   <= err_d;
`ifdef PROG_TIMER_MID_EN
      mid   <= mid_d;
`endif
      if (load) begin
        mode_q <= mode;
        n_q    <= value;
        p_q    <= presc;
      end
    end
  end

endmodule
